// File: rtl/addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : addsub_sequencer
// Brief   : Multi-cycle add/subtract, CHUNK bits per cycle, LSB slice first.
// Revision: 1.0 - initial release
// ============================================================================
module addsub_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             v_flag,
  output logic             z_flag,
  output logic             n_flag
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             sub_q,    sub_d;
  logic             carry_q,  carry_d;
  logic [IDXW-1:0]  idx_q,    idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  logic [CHUNK-1:0] a_cur;
  logic [CHUNK-1:0] b_cur;
  logic [CHUNK-1:0] b_inv;
  logic [CHUNK:0]   slice_sum;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    n_d      = n_q;

    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_cur = a_q[i*CHUNK +: CHUNK];
        b_cur = b_q[i*CHUNK +: CHUNK];
      end
    end
    b_inv     = b_cur ^ {CHUNK{sub_q}};
    slice_sum = {1'b0, a_cur} + {1'b0, b_inv} + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) begin
            result_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
          end
        end
        carry_d = slice_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          // Flags derive from the completed result, so they settle with DONE.
          c_d     = slice_sum[CHUNK];
          v_d     = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                    (result_d[WIDTH-1] != a_q[WIDTH-1]);
          z_d     = (result_d == '0);
          n_d     = result_d[WIDTH-1];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign c_flag = c_q;
  assign v_flag = v_q;
  assign z_flag = z_q;
  assign n_flag = n_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_sequencer
// Brief   : Directed self-checking bench for addsub_sequencer (WIDTH=16, CHUNK=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_addsub_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c_flag;
  logic        v_flag;
  logic        z_flag;
  logic        n_flag;

  int n_pass  = 0;
  int n_total = 0;

  addsub_sequencer #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_flag (c_flag),
    .v_flag (v_flag),
    .z_flag (z_flag),
    .n_flag (n_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issues one operation from IDLE and checks latency, busy span, result and {C,V,Z,N}.
  task automatic do_op(input string tag, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic [15:0] exp_res,
                       input logic [3:0] exp_cvzn);
    int cycles;
    int busy_cycles;
    start = 1'b1;
    sub   = s;
    a     = av;
    b     = bv;
    cycles      = 0;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      start  = 1'b0;
      cycles = cycles + 1;
      if (busy) busy_cycles = busy_cycles + 1;
      if (done) break;
    end
    check({tag, "_latency"}, cycles, 32'd5);
    check({tag, "_busy_cycles"}, busy_cycles, 32'd4);
    check({tag, "_result"}, {16'h0, result}, {16'h0, exp_res});
    check({tag, "_cvzn"}, {28'h0, c_flag, v_flag, z_flag, n_flag}, {28'h0, exp_cvzn});
    tick();
    check({tag, "_idle_after"}, {30'h0, busy, done}, 32'h0);
    check({tag, "_hold"}, {12'h0, result, c_flag, v_flag, z_flag, n_flag},
          {12'h0, exp_res, exp_cvzn});
  endtask

  initial begin
    int dones;
    int done_at [3];
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = 16'h0;
    b     = 16'h0;

    #3;
    check("reset_outputs", {10'h0, busy, done, result, c_flag, v_flag, z_flag, n_flag}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Start issued right away: the first edge after release must accept it.
    do_op("add_1234_0fff", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 4'b0000);
    do_op("sub_5_5",       1'b1, 16'h0005, 16'h0005, 16'h0000, 4'b1010);
    do_op("sub_3_5",       1'b1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0001);
    do_op("add_7fff_1",    1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    do_op("sub_8000_1",    1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100);
    do_op("add_ffff_1",    1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);

    // Start re-pulsed during RUN with different operands must be ignored.
    start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; sub = 1'b1; a = 16'hFFFF; b = 16'h0001;
    tick();
    tick();
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        dones = dones + 1;
        check("ignore_result", {16'h0, result}, 32'h3333);
      end
      tick();
    end
    check("ignore_done_count", dones, 32'd1);

    // Asynchronous reset in the second RUN cycle aborts the operation.
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0FFF;
    tick();
    start = 1'b0;
    tick();
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_async_clear", {15'h0, busy, result}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done || busy) dones = dones + 1;
    end
    check("abort_no_done", dones, 32'd0);
    do_op("after_abort", 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0001);

    // Start held high: back-to-back operations, one done every 6 cycles.
    start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0002;
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        if (dones < 3) done_at[dones] = k;
        dones = dones + 1;
      end
    end
    start = 1'b0;
    check("b2b_done_count", dones, 32'd3);
    check("b2b_first_done", done_at[0], 32'd5);
    check("b2b_period_1", done_at[1] - done_at[0], 32'd6);
    check("b2b_period_2", done_at[2] - done_at[1], 32'd6);
    check("b2b_result", {16'h0, result}, 32'h0003);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
